// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared definitions for the immediate-extension pipeline:
//     - imm_src format-select encodings (IMM_I .. IMM_RSV)
//     - occ_t: occupancy state of the 2-entry output buffer
//     - imm_decode(): combinational immediate decode into a 64-bit value.
//       Callers keep the low XLEN bits. The is64 flag selects the 6-bit
//       shamt field used by RV64.
package imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    // Encoding equals the number of buffered entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // instr carries instruction bits [31:7]. Index k of instr is instruction
    // bit k+7, so instruction bit 31 is instr[24] and bit 7 is instr[0].
    // Every format result is sign-extended to 64 bits, or zero-extended
    // where the format calls for it.
    function automatic logic [63:0] imm_decode(input logic [24:0] instr,
                                               input logic [2:0]  src,
                                               input logic        is64);
        logic        s;
        logic [63:0] imm;
        s   = instr[24];
        imm = '0;
        case (src)
            IMM_I:   imm = {{52{s}}, instr[24:13]};
            IMM_S:   imm = {{52{s}}, instr[24:18], instr[4:0]};
            IMM_B:   imm = {{52{s}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   imm = {{44{s}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:   imm = {{32{s}}, instr[24:5], 12'h000};
            IMM_Z:   imm = {59'h0, instr[12:8]};
            IMM_SH:  imm = is64 ? {58'h0, instr[18:13]} : {59'h0, instr[17:13]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf
//   Generic 2-entry valid/ready buffer with a registered in_ready, so that
//   out_ready never reaches in_ready combinationally. Payload is opaque.
//
//   Handshake: a word moves when valid and ready are both high at a rising
//   edge. Once a producer raises valid, it keeps its data stable until the
//   transfer happens. While out_valid is high and out_ready is low,
//   out_data does not change.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous discard of all buffered entries
//   in_valid/in_ready    upstream handshake; in_data is the payload
//   out_valid/out_ready  downstream handshake; out_data is the head entry
//   state                occupancy FSM state, for debug and checkers
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output occ_t         state
);

    occ_t         state_q;
    occ_t         state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         fire_in;
    logic         fire_out;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid_in;

    assign fire_in  = in_valid & in_ready_q;
    assign fire_out = (state_q != OCC_EMPTY) & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            // Flush wins. A concurrent input is dropped. A concurrent output
            // transfer has already been taken by the consumer.
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (fire_in) begin
                        state_d      = OCC_ONE;
                        load_main_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (fire_in && !fire_out) begin
                        state_d      = OCC_TWO;
                        load_skid_in = 1'b1;
                    end else if (fire_in && fire_out) begin
                        load_main_in = 1'b1;
                    end else if (fire_out) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (fire_out) begin
                        state_d        = OCC_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_TWO);
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
//   Decode-stage immediate extender. The upper instruction bits are decoded
//   combinationally into an XLEN-wide immediate. The immediate, the sideband
//   tag and an illegal-format flag are then registered in a 2-entry buffer
//   behind a valid/ready handshake. Latency is one cycle and throughput is
//   one entry per cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous kill of all buffered entries
//   in_valid/in_ready        upstream handshake (in_ready is registered)
//   in_instr                 instruction bits [31:7]
//   in_imm_src               format select (see imm_pkg)
//   in_tag                   sideband returned with its immediate
//   out_valid/out_ready      downstream handshake
//   out_imm                  extended immediate
//   out_tag                  tag of the presented entry
//   out_illegal              format select was the reserved code
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int PW = XLEN + TAG_W + 1;

    logic [63:0]     dec_full;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   out_payload;
    occ_t            buf_state;
    logic            unused_ok;

    assign dec_full    = imm_decode(in_instr, in_imm_src, (XLEN == 64));
    assign dec_imm     = dec_full[XLEN-1:0];
    assign dec_illegal = (in_imm_src == IMM_RSV);

    // The upper decode bits are meaningful only when XLEN is 64. The buffer
    // state is kept visible for probing.
    assign unused_ok = ^{dec_full, buf_state};

    // Payload layout: {illegal, tag, imm}
    assign in_payload = {dec_illegal, in_tag, dec_imm};

    imm_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload),
        .state    (buf_state)
    );

    assign out_imm     = out_payload[XLEN-1:0];
    assign out_tag     = out_payload[XLEN +: TAG_W];
    assign out_illegal = out_payload[PW-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe
//   Drives one XLEN=32 instance and one XLEN=64 instance from the same
//   inputs. A queue-based model of the expected buffer contents, together
//   with a format decoder written from the immediate definitions, is
//   compared against both instances on every falling edge. Directed
//   sequences add literal expectations.
module tb_imm_ext_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_illegal;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [4:0]  tag;
    } txn_t;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    // Reference immediate value, computed with signed arithmetic on the
    // full 32-bit instruction word.
    function automatic logic [63:0] model_imm(input logic [31:0] ins,
                                              input logic [2:0] src,
                                              input int xlen);
        longint v;
        case (src)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = longint'($signed(ins[31:12])) * 4096;
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the buffer: a FIFO holding at most two entries. The input is
    // accepted when fewer than two entries were held before the edge.
    always @(posedge clk or posedge rst) begin
        bit acc;
        bit pop;
        if (rst) begin
            exp_q.delete();
        end else begin
            acc = in_valid && (exp_q.size() < 2);
            pop = (exp_q.size() > 0) && out_ready;
            if (pop) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (acc) exp_q.push_back('{instr: {in_instr, 7'h0}, src: in_imm_src, tag: in_tag});
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("cyc_in_ready",    64'(in_ready),    64'(exp_q.size() < 2));
            check("cyc_out_valid",   64'(out_valid),   64'(exp_q.size() > 0));
            check("cyc_in_ready64",  64'(in_ready64),  64'(exp_q.size() < 2));
            check("cyc_out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("cyc_imm32",   64'(out_imm),     model_imm(exp_q[0].instr, exp_q[0].src, 32));
                check("cyc_imm64",   out_imm64,        model_imm(exp_q[0].instr, exp_q[0].src, 64));
                check("cyc_tag",     64'(out_tag),     64'(exp_q[0].tag));
                check("cyc_tag64",   64'(out_tag64),   64'(exp_q[0].tag));
                check("cyc_illegal", 64'(out_illegal), 64'(exp_q[0].src == IMM_RSV));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [4:0] tag);
        in_valid   = v;
        in_instr   = instr[31:7];
        in_imm_src = src;
        in_tag     = tag;
    endtask

    // Starts and ends 1 time unit after a rising edge, with the buffer empty.
    task automatic run_one(input string name, input logic [31:0] instr, input logic [2:0] src,
                           input logic [31:0] exp32, input logic [63:0] exp64, input logic exp_ill);
        out_ready = 1'b1;
        drive(1'b1, instr, src, 5'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check(name,             64'(out_imm),   64'(exp32));
        check({name, "_64"},    out_imm64,      exp64);
        check({name, "_ill"},   64'(out_illegal), 64'(exp_ill));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_imm",       64'(out_imm),     64'd0);
        check("rst_tag",       64'(out_tag),     64'd0);
        check("rst_illegal",   64'(out_illegal), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // Literal pins on the reference decoder
        check("model_i",   model_imm(32'hFFF00093, IMM_I, 32), 64'h0000_0000_FFFF_FFFF);
        check("model_b",   model_imm(32'hFE000EE3, IMM_B, 64), 64'hFFFF_FFFF_FFFF_FFFC);
        check("model_j",   model_imm(32'h0040006F, IMM_J, 32), 64'h4);
        check("model_u64", model_imm(32'h80000037, IMM_U, 64), 64'hFFFF_FFFF_8000_0000);

        // Each format, checked against literal results
        run_one("dir_i",   32'hFFF00093, IMM_I,   32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_one("dir_s",   32'hFE000C23, IMM_S,   32'hFFFFFFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        run_one("dir_b",   32'hFE000EE3, IMM_B,   32'hFFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        run_one("dir_j",   32'h0040006F, IMM_J,   32'h00000004, 64'h4, 1'b0);
        run_one("dir_u",   32'h12345037, IMM_U,   32'h12345000, 64'h1234_5000, 1'b0);
        run_one("dir_u_neg", 32'h80000037, IMM_U, 32'h80000000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_one("dir_z",   32'h000A8073, IMM_Z,   32'h00000015, 64'h15, 1'b0);
        run_one("dir_sh",  32'h03F01013, IMM_SH,  32'h0000001F, 64'h3F, 1'b0);

        // Back-pressure: three back-to-back offers with the consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, IMM_I, 5'd1);
        @(posedge clk); #1;
        drive(1'b1, 32'h00200093, IMM_I, 5'd2);
        @(posedge clk); #1;
        drive(1'b1, 32'h00300093, IMM_I, 5'd3);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_head_tag1",    64'(out_tag),  64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_hold_tag1",    64'(out_tag),  64'd1);
        check("bp_hold_imm1",    64'(out_imm),  64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_tag1",   64'(out_tag),  64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_tag2",         64'(out_tag),  64'd2);
        check("bp_ready_back",   64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_tag3",         64'(out_tag),  64'd3);
        check("bp_imm3",         64'(out_imm),  64'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drained",      64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Flush while full, with an input offered in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h00700093, IMM_I, 5'd7);
        @(posedge clk); #1;
        drive(1'b1, 32'h00800093, IMM_I, 5'd8);
        @(posedge clk); #1;
        flush = 1'b1;
        drive(1'b1, 32'h00900093, IMM_I, 5'd9);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_no_ghost",  64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r          = $urandom();
            in_valid   = ($urandom_range(0, 3) != 0);
            in_instr   = r[31:7];
            in_imm_src = 3'($urandom_range(0, 7));
            in_tag     = 5'($urandom_range(0, 31));
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset between edges while an entry is presented
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, IMM_I, 5'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid),   64'd0);
        check("arst_in_ready",  64'(in_ready),    64'd1);
        check("arst_imm",       64'(out_imm),     64'd0);
        check("arst_imm64",     out_imm64,        64'd0);
        check("arst_tag",       64'(out_tag),     64'd0);
        check("arst_illegal",   64'(out_illegal), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_one("dir_rsv", 32'hFFFFFFFF, IMM_RSV, 32'h0, 64'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
